// File: rtl/adder_chk_pkg.sv
// ---------------------------------------------------------------------------
// adder_chk_pkg
//
// Purpose:
//   Shared definitions for the adder sweep checker: the checker state
//   encoding, the default operand width and the behavioural golden adder
//   that every DUT sum is compared against.
//
// Contents:
//   chk_state_t    - checker FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  - default operand width of the adder under test
//   MAX_WIDTH      - widest operand the golden function can model
//   golden_sum()   - zero-extended reference addition with carry-out
// ---------------------------------------------------------------------------
package adder_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    localparam int DEFAULT_WIDTH = 4;

    // The golden function works at a fixed, generous width so that a single
    // definition serves any checker instance. Callers zero-extend their
    // operands, so the upper result bits are always zero for narrower adders.
    localparam int MAX_WIDTH = 16;

    function automatic logic [MAX_WIDTH:0] golden_sum(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH:0] result;
        result = {1'b0, a} + {1'b0, b};
        return result;
    endfunction

endpackage

// File: rtl/sweep_idx_ctr.sv
// ---------------------------------------------------------------------------
// sweep_idx_ctr
//
// Purpose:
//   Sample index for the exhaustive operand sweep. The index encodes the
//   expected operand pair: upper WIDTH bits are operand a (outer loop),
//   lower WIDTH bits are operand b (inner loop).
//
// Ports:
//   clk    in  1         rising-edge clock
//   rst    in  1         synchronous active-high reset
//   clear  in  1         force the index back to zero (start of a sweep)
//   inc    in  1         advance the index by one (one accepted sample)
//   idx    out 2*WIDTH   current sample index
//   last   out 1         idx is at the final sweep position (all ones)
// ---------------------------------------------------------------------------
module sweep_idx_ctr #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [2*WIDTH-1:0]   idx,
    output logic                 last
);

    localparam int IW = 2 * WIDTH;

    // Clear wins over increment; the wrap from all-ones back to zero is the
    // natural overflow of the counter and is harmless because the index is
    // not consulted once the sweep has finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + IW'(1);
        end
    end

    assign last = (idx == {IW{1'b1}});

endmodule

// File: rtl/adder4_sweep_checker.sv
// ---------------------------------------------------------------------------
// adder4_sweep_checker
//
// Purpose:
//   Response checker for an exhaustive sweep of a WIDTH-bit ripple adder.
//   Each (a, b, sum) triple handed over through a valid/ready handshake is
//   compared against a behavioural golden sum, and the operand pair is
//   checked against the expected sweep order (a outer, b inner). After all
//   2^(2*WIDTH) samples the checker reports pass/fail, the number of sum
//   mismatches and the first mismatching triple.
//
// Ports:
//   clk        in  1            rising-edge clock
//   rst        in  1            synchronous active-high reset
//   start      in  1            begin a sweep (ignored while running)
//   in_valid   in  1            producer presents a triple
//   in_ready   out 1            checker accepts a triple this cycle
//   in_a       in  WIDTH        operand a
//   in_b       in  WIDTH        operand b
//   in_sum     in  WIDTH+1      adder sum, carry-out in the MSB
//   busy       out 1            sweep in progress
//   done       out 1            sweep finished, results valid
//   pass       out 1            no mismatches and no order violation
//   err_count  out 2*WIDTH+1    saturating sum-mismatch count
//   order_err  out 1            sticky operand-order violation
//   fail_a     out WIDTH        operand a of first mismatch
//   fail_b     out WIDTH        operand b of first mismatch
//   fail_sum   out WIDTH+1      sum of first mismatch
// ---------------------------------------------------------------------------
module adder4_sweep_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH:0]       in_sum,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic                 order_err,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b,
    output logic [WIDTH:0]       fail_sum
);

    localparam int IW = 2 * WIDTH;
    localparam int EW = 2 * WIDTH + 1;

    chk_state_t          state;
    chk_state_t          state_next;

    logic                accept;
    logic                start_run;
    logic                sum_mismatch;
    logic                order_mismatch;
    logic                have_fail;
    logic [IW-1:0]       idx;
    logic                idx_last;
    logic [MAX_WIDTH:0]  golden;

    // Handshake and sweep-launch qualifiers. A start pulse only launches a
    // sweep from IDLE or DONE; while running it is deliberately ignored.
    assign accept    = in_valid && (state == RUN);
    assign start_run = start && (state != RUN);

    // The golden sum is formed at the package's wide width; the DUT sum is
    // zero-extended to match, so a carry-out error in bit WIDTH is caught
    // and the always-zero upper bits never cause a false mismatch.
    assign golden         = golden_sum(MAX_WIDTH'(in_a), MAX_WIDTH'(in_b));
    assign sum_mismatch   = (golden != (MAX_WIDTH + 1)'(in_sum));
    assign order_mismatch = (in_a != idx[IW-1:WIDTH]) || (in_b != idx[WIDTH-1:0]);

    sweep_idx_ctr #(
        .WIDTH (WIDTH)
    ) u_idx_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (start_run),
        .inc   (accept),
        .idx   (idx),
        .last  (idx_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The sweep ends on the handshake of the final index,
    // so DONE is entered at the same edge that accepts the last sample.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && idx_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result registers. Launching a sweep clears every result in the same
    // edge as the transition into RUN, so a new sweep never inherits the
    // verdict of the previous one. Only the first mismatch is captured;
    // have_fail guards the capture registers for the rest of the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
            order_err <= 1'b0;
            have_fail <= 1'b0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_sum  <= '0;
        end else if (start_run) begin
            err_count <= '0;
            order_err <= 1'b0;
            have_fail <= 1'b0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_sum  <= '0;
        end else if (accept) begin
            if (sum_mismatch) begin
                if (err_count != {EW{1'b1}}) begin
                    err_count <= err_count + EW'(1);
                end
                if (!have_fail) begin
                    have_fail <= 1'b1;
                    fail_a    <= in_a;
                    fail_b    <= in_b;
                    fail_sum  <= in_sum;
                end
            end
            if (order_mismatch) begin
                order_err <= 1'b1;
            end
        end
    end

    // Status outputs are decoded purely from registered state, so no input
    // reaches an output combinationally.
    assign in_ready = (state == RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);
    assign pass     = (state == DONE) && (err_count == '0) && !order_err;

endmodule

// File: tb/tb_adder4_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_adder4_sweep_checker
//
// Directed bench for adder4_sweep_checker with the default 4-bit width.
// Sweeps are generated by the bench with hand-derived sums and faults;
// every result is compared against values the bench states itself.
// ---------------------------------------------------------------------------
module tb_adder4_sweep_checker;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [4:0] in_sum;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic       order_err;
    logic [3:0] fail_a;
    logic [3:0] fail_b;
    logic [4:0] fail_sum;

    int checks = 0;
    int errors = 0;

    adder4_sweep_checker #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sum    (in_sum),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .order_err (order_err),
        .fail_a    (fail_a),
        .fail_b    (fail_b),
        .fail_sum  (fail_sum)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Guard against any hang of the stimulus sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One-cycle start pulse; the checker must be ready in the next cycle.
    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ready_after_start", in_ready, 1);
        checkOutput("busy_after_start", busy, 1);
    endtask

    // Drives a sweep of 'count' samples.
    //   mode 0: correct sums, in order
    //   mode 1: faults at (9,7) -> 5'b00000 and (15,15) -> 5'b01110
    //   mode 2: correct sums, samples 3 and 4 swapped
    // stall inserts random idle cycles; start_in_run pulses start at sample 50.
    task automatic applyStimulus(input int mode, input bit stall, input int count,
                                 input bit start_in_run);
        logic [7:0] kk;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] s;
        for (int k = 0; k < count; k++) begin
            if (stall) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    start    = 1'b0;
                    @(posedge clk);
                end
            end
            kk = 8'(k);
            if (mode == 2 && k == 3) kk = 8'd4;
            if (mode == 2 && k == 4) kk = 8'd3;
            a = kk[7:4];
            b = kk[3:0];
            s = {1'b0, a} + {1'b0, b};
            if (mode == 1 && a == 4'd9 && b == 4'd7) s = 5'b00000;
            if (mode == 1 && a == 4'd15 && b == 4'd15) s = 5'b01110;
            @(negedge clk);
            start = 1'b0;
            if (count == N && k == count - 1) begin
                checkOutput("done_before_last", done, 0);
                checkOutput("ready_before_last", in_ready, 1);
            end
            in_a     = a;
            in_b     = b;
            in_sum   = s;
            in_valid = 1'b1;
            if (start_in_run && k == 50) start = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        if (count == N) begin
            checkOutput("done_after_last", done, 1);
            checkOutput("ready_after_last", in_ready, 0);
            checkOutput("busy_after_last", busy, 0);
        end
    endtask

    task automatic checkResults(input string name, input logic exp_pass,
                                input int exp_err, input logic exp_order,
                                input int exp_fa, input int exp_fb, input int exp_fs);
        checkOutput({name, "_pass"}, pass, exp_pass);
        checkOutput({name, "_err_count"}, err_count, exp_err);
        checkOutput({name, "_order_err"}, order_err, exp_order);
        checkOutput({name, "_fail_a"}, fail_a, exp_fa);
        checkOutput({name, "_fail_b"}, fail_b, exp_fb);
        checkOutput({name, "_fail_sum"}, fail_sum, exp_fs);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_in_ready"}, in_ready, 0);
        checkOutput({name, "_busy"}, busy, 0);
        checkOutput({name, "_done"}, done, 0);
        checkResults(name, 1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_sum   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", in_ready, 0);

        $display("[TB] correct sweep");
        pulseStart();
        applyStimulus(0, 1'b0, N, 1'b0);
        checkResults("correct", 1'b1, 0, 1'b0, 0, 0, 0);

        $display("[TB] injected fault sweep");
        pulseStart();
        applyStimulus(1, 1'b0, N, 1'b0);
        checkResults("fault", 1'b0, 2, 1'b0, 9, 7, 0);

        // Start from DONE together with a bad triple: the triple must not
        // be accepted and the previous results must clear.
        $display("[TB] start in DONE with in_valid");
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_a     = 4'd3;
        in_b     = 4'd3;
        in_sum   = 5'h1f;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("restart_ready", in_ready, 1);
        checkOutput("restart_done", done, 0);
        checkResults("restart", 1'b0, 0, 1'b0, 0, 0, 0);

        $display("[TB] start pulsed during run");
        applyStimulus(0, 1'b0, N, 1'b1);
        checkResults("start_in_run", 1'b1, 0, 1'b0, 0, 0, 0);

        $display("[TB] order violation sweep");
        pulseStart();
        applyStimulus(2, 1'b0, N, 1'b0);
        checkResults("order", 1'b0, 0, 1'b1, 0, 0, 0);

        $display("[TB] stalled sweep");
        pulseStart();
        applyStimulus(0, 1'b1, N, 1'b0);
        checkResults("stall", 1'b1, 0, 1'b0, 0, 0, 0);

        $display("[TB] reset mid-run");
        pulseStart();
        applyStimulus(1, 1'b0, 100, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("midreset");
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_stays_idle", in_ready, 0);
        pulseStart();
        applyStimulus(0, 1'b0, N, 1'b0);
        checkResults("rerun", 1'b1, 0, 1'b0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder4_sweep_checker.md
# adder4_sweep_checker

Synthesizable response checker for the 4-bit ripple adder (`FourBitAdder`) and its exhaustive sweep stimulus. It consumes (a, b, sum) triples through a valid/ready handshake and compares each sum against a behavioural golden sum. It also confirms that the operands arrive in sweep order: a outer loop, b inner loop, 0..15 each. When all 2^(2·WIDTH) vectors have been accepted, it reports pass/fail, the error count and the first failing vector.

## Interface
- `WIDTH`, default 4: operand width. The sweep length is N = 2^(2·WIDTH), which is 256 by default.
- `clk` in 1: sole clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a sweep. It is honoured in IDLE or DONE and ignored in RUN.
- `in_valid` in 1: the producer has a triple on `in_a`/`in_b`/`in_sum`.
- `in_ready` out 1: the checker can accept; equal to (state == RUN).
- `in_a` in WIDTH: operand a.
- `in_b` in WIDTH: operand b.
- `in_sum` in WIDTH+1: DUT sum, carry-out in the MSB.
- `busy` out 1: state == RUN.
- `done` out 1: state == DONE.
- `pass` out 1: valid while `done`; equals (err_count == 0) && !order_err.
- `err_count` out 2·WIDTH+1: number of sum mismatches; saturates at all-ones.
- `order_err` out 1: sticky; set when an operand pair deviates from the expected sweep order.
- `fail_a` out WIDTH, `fail_b` out WIDTH, `fail_sum` out WIDTH+1: the first mismatching triple. Zero if there is none.

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → DONE on acceptance of sample index N−1.
  - DONE → RUN on `start`.
  - No other transitions.
- Entering RUN, in the same edge as the transition:
  - `idx`, `err_count`, `order_err`, `fail_*` and the internal `have_fail` flag all clear to 0.
- Acceptance: `in_valid && in_ready` at a rising edge.
- Golden sum: zero-extend `in_a` and `in_b` to WIDTH+1, then add. No truncation; the carry is bit WIDTH.
- On each acceptance:
  - Sum mismatch (`in_sum` ≠ golden): `err_count` increments, saturating.
  - If `have_fail` is 0, capture `in_a`/`in_b`/`in_sum` into `fail_*` and set `have_fail`.
  - Order check: `in_a` ≠ idx[2W−1:W] or `in_b` ≠ idx[W−1:0] sets `order_err`. Sum checking is unaffected.
  - `idx` increments by 1. At N−1 the FSM moves to DONE; `idx` wraps to 0 but is unused in DONE.
- `in_valid` low in RUN: no state change; the checker waits indefinitely, with no timeout.
- In DONE all results hold until `start` or `rst`.
- `start` and `in_valid` together in IDLE/DONE: only the transition occurs. No sample is accepted in that cycle because `in_ready` was 0.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready`, `busy`, `done`, `pass`, `order_err` = 0.
  - `err_count`, `fail_*` = 0.
- `rst` mid-RUN abandons the sweep. All outputs return to their reset values at that edge, and `start` is required to rerun.
- `rst` has priority over `start` and over acceptance.
- All outputs are registered, or decoded from registered state only. No combinational path from any input to any output.
- `start` at edge E: `in_ready` is high from cycle E+1.
- The result of a sample accepted at edge E is visible from cycle E+1.
- Final acceptance at edge E: `in_ready` falls and `done`/`pass` are valid from cycle E+1.
- Throughput: one sample per clock. Minimum sweep time is N cycles from the first `in_ready`.

## Structure
- Shared package `adder_chk_pkg`:
  - state enum `chk_state_t` {IDLE, RUN, DONE};
  - default `WIDTH` localparam;
  - function `golden_sum(a, b)` returning WIDTH+1 bits.
- One natural sub-module, `sweep_idx_ctr`:
  - 2·WIDTH-bit counter with clear, increment and a `last` flag (idx == N−1);
  - this flag drives the RUN→DONE transition.
- Everything else (FSM, comparators, capture registers, saturating counter) lives in the top module.

## Test plan
- Correct exhaustive sweep:
  - stimulus: `start`, then 256 in-order triples with correct sums, `in_valid` held high;
  - response: `done` in the cycle after the 256th acceptance, `pass`=1, `err_count`=0, `order_err`=0, `fail_*`=0.
- Injected fault:
  - stimulus: sweep in which a=9, b=7 carries `in_sum`=5'b00000 instead of 5'b10000, and a=15, b=15 carries 5'b01110 instead of 5'b11110;
  - response: `err_count`=2, `fail_a`=9, `fail_b`=7, `fail_sum`=0, `pass`=0.
- Order violation:
  - stimulus: correct sums, but samples 3 and 4 swapped (b=4 is sent before b=3);
  - response: `order_err`=1, `err_count`=0, `pass`=0.
- Stalls:
  - stimulus: random `in_valid` gaps, about 50% duty;
  - response: the same result as the first scenario; `idx` advances only on acceptance, and `done` appears exactly one cycle after the 256th handshake.
- Reset mid-run and restart:
  - stimulus: `rst` after 100 samples, then `start` and a full correct sweep;
  - response: all outputs are 0 the cycle after `rst`; the final `pass`=1 and `err_count`=0.
- Start handling:
  - stimulus: `start` pulsed during RUN, then again in DONE;
  - response: the pulse in RUN is ignored (`idx` is unaffected); the pulse in DONE clears the results and `in_ready`=1 the next cycle.
